// File: rtl/shift_register_univ.sv
// Universal N-bit register: hold, shift right/left, rotate and parallel load,
// with synchronous clear/preset, a chip-rate clock enable, serial I/O and a
// shift counter that pulses word_done once per completed NUM_BITS-shift word.
module shift_register_univ #(
    parameter int                      NUM_BITS  = 8,
    parameter int                      CNT_W     = $clog2(NUM_BITS + 1),
    parameter logic [NUM_BITS-1:0]     RESET_VAL = {NUM_BITS{1'b0}}
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                ce,
    input  logic                clear_n,
    input  logic                preset_n,
    input  logic [1:0]          mode,
    input  logic                rotate,
    input  logic                ser_r,
    input  logic                ser_l,
    input  logic [NUM_BITS-1:0] p,
    output logic [NUM_BITS-1:0] q,
    output logic [NUM_BITS-1:0] q_n,
    output logic                ser_out_r,
    output logic                ser_out_l,
    output logic [CNT_W-1:0]    shift_cnt,
    output logic                word_done
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    // Count value reached just before the shift that completes a word.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS - 1);

    mode_e               mode_sel;
    logic                in_r;
    logic                in_l;
    logic [NUM_BITS-1:0] shr_val;
    logic [NUM_BITS-1:0] shl_val;
    logic                word_end;

    assign mode_sel  = mode_e'(mode);
    assign q_n       = ~q;
    assign ser_out_r = q[0];
    assign ser_out_l = q[NUM_BITS-1];
    assign word_end  = (shift_cnt == LAST_CNT);

    // Pick the incoming bit for each direction: recirculated bit or serial input.
    always_comb begin
        in_r = ser_r;
        in_l = ser_l;
        if (rotate) begin
            in_r = q[0];
            in_l = q[NUM_BITS-1];
        end
    end

    // A one-bit register has nothing to slide, so both shifts just take the
    // incoming bit; rotate then recirculates q[0] onto itself.
    generate
        if (NUM_BITS == 1) begin : g_single
            assign shr_val = in_r;
            assign shl_val = in_l;
        end else begin : g_multi
            assign shr_val = {in_r, q[NUM_BITS-1:1]};
            assign shl_val = {q[NUM_BITS-2:0], in_l};
        end
    endgenerate

    // Register update: clear beats preset, both ignore ce; mode ops need ce.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            q         <= RESET_VAL;
            shift_cnt <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (!clear_n) begin
                q         <= '0;
                shift_cnt <= '0;
            end else if (!preset_n) begin
                q         <= '1;
                shift_cnt <= '0;
            end else if (ce) begin
                case (mode_sel)
                    MODE_HOLD: begin
                        q <= q;
                    end
                    MODE_LOAD: begin
                        q         <= p;
                        shift_cnt <= '0;
                    end
                    MODE_RIGHT, MODE_LEFT: begin
                        q <= (mode_sel == MODE_RIGHT) ? shr_val : shl_val;
                        if (word_end) begin
                            shift_cnt <= '0;
                            word_done <= 1'b1;
                        end else begin
                            shift_cnt <= shift_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        q <= q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_register_univ.sv
// Self-checking bench for shift_register_univ (8-bit) against an arithmetic
// reference model: directed scenarios followed by randomized control traffic.
module tb_shift_register_univ;

    localparam int NUM_BITS = 8;
    localparam int CNT_W    = $clog2(NUM_BITS + 1);

    logic                Clk;
    logic                Reset_n;
    logic                ce;
    logic                clear_n;
    logic                preset_n;
    logic [1:0]          mode;
    logic                rotate;
    logic                ser_r;
    logic                ser_l;
    logic [NUM_BITS-1:0] p;
    logic [NUM_BITS-1:0] q;
    logic [NUM_BITS-1:0] q_n;
    logic                ser_out_r;
    logic                ser_out_l;
    logic [CNT_W-1:0]    shift_cnt;
    logic                word_done;

    int checkCount = 0;
    int passCount  = 0;

    int modelQ;
    int modelCnt;
    int modelDone;
    int pulseCount;

    shift_register_univ #(.NUM_BITS(NUM_BITS)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .ce        (ce),
        .clear_n   (clear_n),
        .preset_n  (preset_n),
        .mode      (mode),
        .rotate    (rotate),
        .ser_r     (ser_r),
        .ser_l     (ser_l),
        .p         (p),
        .q         (q),
        .q_n       (q_n),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    // Free-running 10-unit clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        else
            passCount++;
    endtask

    // Compare every DUT output against the reference model.
    task automatic checkAll(input string tag);
        checkOutput({tag, ".q"},         32'(q),         32'(modelQ));
        checkOutput({tag, ".q_n"},       32'(q_n),       32'((~modelQ) & 8'hFF));
        checkOutput({tag, ".ser_out_r"}, 32'(ser_out_r), 32'(modelQ % 2));
        checkOutput({tag, ".ser_out_l"}, 32'(ser_out_l), 32'(modelQ / 128));
        checkOutput({tag, ".shift_cnt"}, 32'(shift_cnt), 32'(modelCnt));
        checkOutput({tag, ".word_done"}, 32'(word_done), 32'(modelDone));
    endtask

    // Reference behaviour for one rising edge, written with plain arithmetic.
    task automatic modelStep();
        int inBit;
        modelDone = 0;
        if (!clear_n) begin
            modelQ   = 0;
            modelCnt = 0;
        end else if (!preset_n) begin
            modelQ   = 255;
            modelCnt = 0;
        end else if (ce) begin
            if (mode == 2'd3) begin
                modelQ   = int'(p);
                modelCnt = 0;
            end else if (mode == 2'd1 || mode == 2'd2) begin
                if (mode == 2'd1) begin
                    inBit  = rotate ? (modelQ % 2) : int'(ser_r);
                    modelQ = (modelQ / 2) + inBit * 128;
                end else begin
                    inBit  = rotate ? (modelQ / 128) : int'(ser_l);
                    modelQ = ((modelQ * 2) % 256) + inBit;
                end
                modelCnt = modelCnt + 1;
                if (modelCnt == NUM_BITS) begin
                    modelCnt  = 0;
                    modelDone = 1;
                end
            end
        end
    endtask

    // Drive one cycle of controls, take the edge, advance the model and check.
    task automatic applyStimulus(input string tag, input logic ceV, input logic clrV,
                                 input logic preV, input logic [1:0] modeV,
                                 input logic rotV, input logic serRV, input logic serLV,
                                 input logic [7:0] pV);
        ce       = ceV;
        clear_n  = clrV;
        preset_n = preV;
        mode     = modeV;
        rotate   = rotV;
        ser_r    = serRV;
        ser_l    = serLV;
        p        = pV;
        @(posedge Clk);
        #1;
        if (Reset_n) modelStep();
        if (word_done === 1'b1) pulseCount++;
        checkAll(tag);
    endtask

    // Drop reset between edges; outputs must clear without waiting for Clk.
    task automatic assertReset(input string tag);
        #2;
        Reset_n   = 1'b0;
        #1;
        modelQ    = 0;
        modelCnt  = 0;
        modelDone = 0;
        checkAll(tag);
    endtask

    initial begin
        Reset_n  = 1'b0;
        ce       = 1'b0;
        clear_n  = 1'b1;
        preset_n = 1'b1;
        mode     = 2'd0;
        rotate   = 1'b0;
        ser_r    = 1'b0;
        ser_l    = 1'b0;
        p        = '0;
        modelQ   = 0;
        modelCnt = 0;
        modelDone = 0;
        pulseCount = 0;

        #2;
        checkAll("por");
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // Reset while holding 5A: immediate clear, held across an edge.
        applyStimulus("load5A", 1, 1, 1, 2'd3, 0, 0, 0, 8'h5A);
        assertReset("rstAsync");
        applyStimulus("rstHeld", 1, 1, 1, 2'd3, 0, 0, 0, 8'hA5);
        checkOutput("rstHeldQ", 32'(q), 32'h00);
        Reset_n = 1'b1;

        // Load A5 then hold three edges.
        applyStimulus("loadA5", 1, 1, 1, 2'd3, 0, 0, 0, 8'hA5);
        checkOutput("loadA5Q", 32'(q), 32'hA5);
        for (int i = 0; i < 3; i++) applyStimulus("hold", 1, 1, 1, 2'd0, 0, 0, 0, 8'h00);

        // Shift right with ser_r=1 for a full word.
        pulseCount = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus("shr", 1, 1, 1, 2'd1, 0, 1, 0, 8'h00);
            if (i == 0) checkOutput("shrFirst", 32'(q), 32'hD2);
            if (i == 1) checkOutput("shrSecond", 32'(q), 32'hE9);
        end
        checkOutput("shrEndQ", 32'(q), 32'hFF);
        checkOutput("shrEndDone", 32'(word_done), 32'd1);
        applyStimulus("shrAfter", 1, 1, 1, 2'd0, 0, 0, 0, 8'h00);
        checkOutput("shrPulses", 32'(pulseCount), 32'd1);

        // Rotate left from 81 for a full word.
        applyStimulus("load81", 1, 1, 1, 2'd3, 0, 0, 0, 8'h81);
        pulseCount = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus("rol", 1, 1, 1, 2'd2, 1, 0, 0, 8'h00);
            if (i == 0) checkOutput("rolFirst", 32'(q), 32'h03);
            if (i == 1) checkOutput("rolSecond", 32'(q), 32'h06);
        end
        checkOutput("rolEndQ", 32'(q), 32'h81);
        checkOutput("rolPulses", 32'(pulseCount), 32'd1);

        // Clear beats preset, both ignore ce.
        applyStimulus("clrPre", 0, 0, 0, 2'd3, 0, 0, 0, 8'h5A);
        checkOutput("clrPreQ", 32'(q), 32'h00);
        applyStimulus("preOnly", 0, 1, 0, 2'd3, 0, 0, 0, 8'h5A);
        checkOutput("preOnlyQ", 32'(q), 32'hFF);

        // Reach 3C with count 3, then gate with ce.
        applyStimulus("load87", 1, 1, 1, 2'd3, 0, 0, 0, 8'h87);
        applyStimulus("shl1", 1, 1, 1, 2'd2, 0, 0, 1, 8'h00);
        applyStimulus("shl0a", 1, 1, 1, 2'd2, 0, 0, 0, 8'h00);
        applyStimulus("shl0b", 1, 1, 1, 2'd2, 0, 0, 0, 8'h00);
        checkOutput("gateQ", 32'(q), 32'h3C);
        checkOutput("gateCnt", 32'(shift_cnt), 32'd3);
        for (int i = 0; i < 5; i++) applyStimulus("ceOff", 0, 1, 1, 2'd2, 0, 0, 0, 8'h00);
        pulseCount = 0;
        for (int i = 0; i < 5; i++) applyStimulus("ceOn", 1, 1, 1, 2'd2, 0, 0, 1, 8'h00);
        checkOutput("ceOnDone", 32'(word_done), 32'd1);
        checkOutput("ceOnPulses", 32'(pulseCount), 32'd1);

        // Mid-word reset aborts the word: no pulse afterwards.
        for (int i = 0; i < 6; i++) applyStimulus("abort", 1, 1, 1, 2'd1, 0, 0, 0, 8'h00);
        assertReset("abortRst");
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        pulseCount = 0;
        for (int i = 0; i < 2; i++) applyStimulus("afterAbort", 1, 1, 1, 2'd1, 0, 1, 0, 8'h00);
        checkOutput("abortPulses", 32'(pulseCount), 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                assertReset("rndRst");
                @(posedge Clk);
                #1;
                Reset_n = 1'b1;
            end
            applyStimulus("rnd",
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 19) != 0),
                          1'($urandom_range(0, 19) != 0),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/shift_register_univ.md
Name: shift_register_univ

Overview:
- Parametrised universal register. It generalises the single clear/preset flip-flop to an N-bit register with hold, shift-right, shift-left, rotate and parallel-load modes.
- Adds a clock enable, serial I/O and a shift counter that flags each completed word.
- Intended for video/disk serialisers and latch chains in the Apple II datapath, where a 74LS194/74LS166-style part is modelled on the fast system clock using ce as the chip-rate strobe.

Parameters:
- NUM_BITS, 8, register width; must be >= 1.
- CNT_W, $clog2(NUM_BITS+1), width of shift_cnt; derived, not overridden.
- RESET_VAL, {NUM_BITS{1'b0}}, value of q on asynchronous reset.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- ce  input  1  clock enable for mode operations.
- clear_n  input  1  synchronous clear, active-low.
- preset_n  input  1  synchronous preset, active-low.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- rotate  input  1  when 1, shifts recirculate the outgoing bit instead of using serial input.
- ser_r  input  1  serial input entering q[NUM_BITS-1] on shift right.
- ser_l  input  1  serial input entering q[0] on shift left.
- p  input  NUM_BITS  parallel load data.
- q  output  NUM_BITS  register contents.
- q_n  output  NUM_BITS  ~q, combinational.
- ser_out_r  output  1  q[0], the bit leaving on shift right.
- ser_out_l  output  1  q[NUM_BITS-1], the bit leaving on shift left.
- shift_cnt  output  CNT_W  number of shifts since last load/clear/preset/wrap.
- word_done  output  1  one-cycle registered pulse on completion of NUM_BITS shifts.

Behaviour:
- Reset_n=0 takes effect immediately, independent of Clk, and holds while low:
  - q=RESET_VAL, q_n=~RESET_VAL;
  - shift_cnt=0, word_done=0.
- Release of Reset_n takes effect at the next Clk edge; no other reset exists.
- Priority at each rising Clk edge, highest first:
  - clear_n=0 -> q=all 0s; this wins over preset_n=0. Acts regardless of ce.
  - preset_n=0 -> q=all 1s. Acts regardless of ce.
  - ce=0 -> q and shift_cnt hold; word_done <= 0.
  - ce=1, mode=00 -> hold; word_done <= 0.
  - ce=1, mode=11 -> q <= p.
  - ce=1, mode=01 -> q <= {in, q[NUM_BITS-1:1]}; in = rotate ? q[0] : ser_r.
  - ce=1, mode=10 -> q <= {q[NUM_BITS-2:0], in}; in = rotate ? q[NUM_BITS-1] : ser_l.
- NUM_BITS=1: both shifts give q <= in. Rotate leaves q unchanged.
- Counter:
  - Clear, preset and load set shift_cnt=0 and word_done=0.
  - Each executed shift (either direction, rotate or not) increments shift_cnt.
  - When the increment would reach NUM_BITS, shift_cnt wraps to 0 and word_done=1 for exactly the following cycle.
  - Hold and ce=0 leave shift_cnt unchanged.
  - word_done is 0 on every edge that does not complete a word, so back-to-back words give isolated pulses NUM_BITS cycles apart.
- Latency:
  - q, shift_cnt and word_done are updated at the edge that samples the controls: one cycle.
  - q_n, ser_out_r and ser_out_l follow q combinationally.
- Direction changes mid-word are legal; the counter keeps counting shifts regardless of direction.
- Reset_n asserted mid-word aborts the word; no word_done is produced.

Test Plan:
- Reset: hold Reset_n=0 between Clk edges with q=5A -> q=00, q_n=FF, shift_cnt=0, word_done=0 before the next edge; stays so until Reset_n=1 and an edge.
- Load/hold: ce=1, mode=11, p=A5 for one edge -> q=A5, ser_out_r=1, ser_out_l=1. Then mode=00 for 3 edges -> q=A5, shift_cnt=0.
- Shift right into full word: from A5, mode=01, ser_r=1, rotate=0 for 8 edges:
  - q=D2 then E9, ... ending at FF;
  - shift_cnt=1..7 then 0;
  - word_done=1 only in the cycle after the 8th edge.
- Rotate left: load 81, mode=10, rotate=1, ser_l=0 -> q=03 then 06. After 8 rotations q=81 and word_done pulses once.
- Clear/preset priority: clear_n=0, preset_n=0, ce=0, mode=11, p=5A -> q=00, shift_cnt=0. Then clear_n=1, preset_n=0 -> q=FF.
- Enable gating: q=3C, shift_cnt=3, ce=0, mode=10 for 5 edges -> q=3C, shift_cnt=3, word_done=0. Then ce=1 for 5 edges -> word_done pulses after the 5th.
